// File: rtl/gmem_rect_fill.sv
// Rectangle-fill engine: writes a solid colour rectangle into the 320x240 gmem in raster order.
// Optional macro RECT_FILL_CLIP_EN clips partly off-frame rectangles instead of rejecting them.
module gmem_rect_fill #(
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_w,
    input  logic [7:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               gmem_we,
    output logic [ADDR_W-1:0]  gmem_waddr,
    output logic [COLOR_W-1:0] gmem_wdat,
    input  logic               gmem_wready,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [9:0]        FB_W10 = 10'(FB_W);
    localparam logic [9:0]        FB_H10 = 10'(FB_H);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_W);

    state_t state_reg, state_next;

    logic [8:0]         x0_reg;
    logic [7:0]         y0_reg;
    logic [8:0]         w_reg;
    logic [7:0]         h_reg;
    logic [COLOR_W-1:0] color_reg;
    logic [COLOR_W-1:0] wdat_reg;
    logic [9:0]         x_reg, y_reg, last_x_reg, last_y_reg;
    logic [ADDR_W-1:0]  row_base_reg, addr_reg;
    logic               err_reg;

    // Setup-time bounds evaluated at 10 bits so x0+w / y0+h never wrap
    logic [9:0]        x_end, y_end, last_x_calc, last_y_calc;
    logic              zero_size, reject;
    logic [ADDR_W-1:0] row_base_calc;
    logic              last_beat;

    assign x_end     = {1'b0, x0_reg} + {1'b0, w_reg};
    assign y_end     = {2'b0, y0_reg} + {2'b0, h_reg};
    assign zero_size = (w_reg == 9'd0) || (h_reg == 8'd0);

`ifdef RECT_FILL_CLIP_EN
    assign reject      = ({1'b0, x0_reg} >= FB_W10) || ({2'b0, y0_reg} >= FB_H10);
    assign last_x_calc = ((x_end > FB_W10) ? FB_W10 : x_end) - 10'd1;
    assign last_y_calc = ((y_end > FB_H10) ? FB_H10 : y_end) - 10'd1;
`else
    assign reject      = (x_end > FB_W10) || (y_end > FB_H10);
    assign last_x_calc = x_end - 10'd1;
    assign last_y_calc = y_end - 10'd1;
`endif

    // y*320 = (y<<8) + (y<<6): shift-add instead of a multiplier
    assign row_base_calc = ADDR_W'({y0_reg, 8'b0}) + ADDR_W'({y0_reg, 6'b0});
    assign last_beat     = gmem_wready && (x_reg == last_x_reg) && (y_reg == last_y_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        gmem_we    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~rst;
                if (cmd_valid && !rst) state_next = SETUP;
            end
            SETUP: state_next = (zero_size || reject) ? DONE : FILL;
            FILL: begin
                gmem_we = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            color_reg    <= '0;
            wdat_reg     <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            last_x_reg   <= '0;
            last_y_reg   <= '0;
            row_base_reg <= '0;
            addr_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (cmd_valid) begin
                    x0_reg    <= cmd_x0;
                    y0_reg    <= cmd_y0;
                    w_reg     <= cmd_w;
                    h_reg     <= cmd_h;
                    color_reg <= cmd_color;
                    err_reg   <= 1'b0;
                end
                SETUP: begin
                    x_reg        <= {1'b0, x0_reg};
                    y_reg        <= {2'b0, y0_reg};
                    last_x_reg   <= last_x_calc;
                    last_y_reg   <= last_y_calc;
                    row_base_reg <= row_base_calc;
                    addr_reg     <= row_base_calc + ADDR_W'(x0_reg);
                    wdat_reg     <= color_reg;
                    err_reg      <= ~zero_size & reject;
                end
                FILL: if (gmem_wready) begin
                    if (x_reg == last_x_reg) begin
                        x_reg        <= {1'b0, x0_reg};
                        y_reg        <= y_reg + 10'd1;
                        row_base_reg <= row_base_reg + STRIDE;
                        addr_reg     <= row_base_reg + STRIDE + ADDR_W'(x0_reg);
                    end else begin
                        x_reg    <= x_reg + 10'd1;
                        addr_reg <= addr_reg + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign gmem_waddr = addr_reg;
    assign gmem_wdat  = wdat_reg;
endmodule
